sysid_check_master: RTL and testbench

Avalon-MM read master that interrogates the system ID peripheral at boot or on request: it reads the ID word (word address 0) then the timestamp word (word address 1), compares both against build-time parameters, and reports pass/fail with an error code. It sits beside the Nios II host on the system interconnect as a hardware self-check, driving the sysid control slave's read port.

---
 rtl/sysid_check_master.sv | 147 ++++++++++++++
 tb/tb_sysid_check_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read master that fetches the system ID word
// (address 0) and the build timestamp (address 1), compares both against
// build-time constants and reports pass/fail plus an error code.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1363592293,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  error,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ID   = 2'd1;
    localparam logic [1:0] ERR_TS   = 2'd2;
    localparam logic [1:0] ERR_TOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WAIT_ID,
        RD_TS,
        WAIT_TS,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Timeout fires on the last allowed cycle of a transaction; the
    // completing event of that same cycle takes priority in the FSM below.
    logic expired;
    assign expired = (cnt == CNT_LAST);

    // Check sequencer: every output is a register updated with the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            avm_read        <= 1'b0;
            avm_address     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            error           <= ERR_NONE;
            id_value        <= '0;
            timestamp_value <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RD_ID;
                        cnt         <= '0;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        error       <= ERR_NONE;
                    end
                end
                RD_ID, RD_TS: begin
                    // Request stays untouched while the slave stalls.
                    if (!avm_waitrequest) begin
                        state    <= (state == RD_ID) ? WAIT_ID : WAIT_TS;
                        avm_read <= 1'b0;
                        cnt      <= cnt + 1'b1;
                    end else if (expired) begin
                        state    <= DONE;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        error    <= ERR_TOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_ID: begin
                    if (avm_readdatavalid) begin
                        id_value <= avm_readdata;
                        if (avm_readdata == EXPECTED_ID) begin
                            state       <= RD_TS;
                            cnt         <= '0;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b1;
                        end else begin
                            // Timestamp is not worth reading once the ID is wrong.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            error <= ERR_ID;
                        end
                    end else if (expired) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= ERR_TOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_TS: begin
                    if (avm_readdatavalid) begin
                        timestamp_value <= avm_readdata;
                        state           <= DONE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        if (avm_readdata == EXPECTED_TIMESTAMP) begin
                            pass  <= 1'b1;
                            error <= ERR_NONE;
                        end else begin
                            error <= ERR_TS;
                        end
                    end else if (expired) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= ERR_TOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master: directed checks of the sysid read master against a
// small reactive Avalon slave (programmable stalls, 1-cycle read latency).
module tb_sysid_check_master;

    localparam logic [31:0] TS_GOOD = 32'd1363592293;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, pass;
    logic [1:0]  error;
    logic [31:0] id_value, timestamp_value;

    sysid_check_master #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS_GOOD),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .error             (error),
        .id_value          (id_value),
        .timestamp_value   (timestamp_value)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Slave configuration and observation counters.
    logic [31:0] id_val = 32'd0;
    logic [31:0] ts_val = TS_GOOD;
    int          nwait = 0;
    bit          stuck = 0;
    bit          inj   = 0;
    int          seen = 0;
    bit          acc = 0;
    bit          acc_addr = 0;
    bit          prev_rd = 0, prev_wr = 0, prev_addr = 0;
    int          stab_err = 0;
    int          addr1_reads = 0;

    // Reactive slave: decides waitrequest/response once per cycle, just after the edge.
    always @(posedge clock) begin
        logic        wr, rdv;
        logic [31:0] rdata;
        #1;
        if (prev_rd && prev_wr && !done && reset_n &&
            (avm_read !== 1'b1 || avm_address !== prev_addr))
            stab_err++;
        if (avm_read && avm_address) addr1_reads++;
        rdv   = 1'b0;
        rdata = 32'h0;
        if (acc) begin
            rdv   = 1'b1;
            rdata = acc_addr ? ts_val : id_val;
            acc   = 0;
        end
        if (inj) begin
            rdv   = 1'b1;
            rdata = 32'hDEADBEEF;
        end
        wr = 1'b0;
        if (avm_read && reset_n) begin
            if (stuck || seen < nwait) begin
                wr = 1'b1;
                seen++;
            end else begin
                seen     = 0;
                acc      = 1;
                acc_addr = avm_address;
            end
        end
        if (!reset_n) acc = 0;
        prev_rd   = avm_read;
        prev_wr   = wr;
        prev_addr = avm_address;
        avm_waitrequest   = wr;
        avm_readdatavalid = rdv;
        avm_readdata      = rdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(output int k);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        k = cyc;
    endtask

    // Edges from the start edge until done is first seen high (bounded).
    task automatic wait_done(input int k, output int d);
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!done) check("done_wait_timeout", 32'(done), 32'd1);
        d = cyc - k;
    endtask

    task automatic new_test(input logic [31:0] idv, input logic [31:0] tsv, input int nw);
        id_val = idv; ts_val = tsv; nwait = nw; stuck = 0; inj = 0;
        seen = 0; stab_err = 0; addr1_reads = 0;
    endtask

    initial begin
        int k, k2, d, rd_hi;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Nominal check: no stalls, latency 1
        new_test(32'd0, TS_GOOD, 0);
        pulse_start(k);
        check("nom_read_k1", 32'(avm_read), 32'd1);
        check("nom_addr_k1", 32'(avm_address), 32'd0);
        check("nom_busy_k1", 32'(busy), 32'd1);
        wait_done(k, d);
        check("nom_latency", 32'(d), 32'd4);
        check("nom_pass", 32'(pass), 32'd1);
        check("nom_error", 32'(error), 32'd0);
        check("nom_id", id_value, 32'd0);
        check("nom_ts", timestamp_value, TS_GOOD);
        check("nom_busy_done", 32'(busy), 32'd0);
        check("nom_read_done", 32'(avm_read), 32'd0);

        // ID mismatch: timestamp never requested
        new_test(32'h5, TS_GOOD, 0);
        pulse_start(k);
        wait_done(k, d);
        check("idmm_latency", 32'(d), 32'd2);
        check("idmm_pass", 32'(pass), 32'd0);
        check("idmm_error", 32'(error), 32'd1);
        check("idmm_id", id_value, 32'h5);
        repeat (3) @(posedge clock);
        #1;
        check("idmm_no_addr1", 32'(addr1_reads), 32'd0);

        // Timestamp mismatch with 3 stall cycles per read
        new_test(32'd0, 32'h12345678, 3);
        pulse_start(k);
        wait_done(k, d);
        check("tsmm_latency", 32'(d), 32'd10);
        check("tsmm_error", 32'(error), 32'd2);
        check("tsmm_pass", 32'(pass), 32'd0);
        check("tsmm_ts", timestamp_value, 32'h12345678);
        check("tsmm_stable", 32'(stab_err), 32'd0);

        // Timeout on stuck waitrequest, late responses ignored
        new_test(32'd0, TS_GOOD, 0);
        stuck = 1;
        pulse_start(k);
        wait_done(k, d);
        check("tout_latency", 32'(d), 32'd8);
        check("tout_error", 32'(error), 32'd3);
        check("tout_read_low", 32'(avm_read), 32'd0);
        check("tout_stable", 32'(stab_err), 32'd0);
        stuck = 0;
        inj = 1;
        rd_hi = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (avm_read) rd_hi++;
        end
        inj = 0;
        repeat (2) @(posedge clock);
        #1;
        check("late_done", 32'(done), 32'd1);
        check("late_error", 32'(error), 32'd3);
        check("late_id", id_value, 32'd0);
        check("late_ts", timestamp_value, 32'h12345678);
        check("late_no_read", 32'(rd_hi), 32'd0);

        // start while busy is ignored; start in DONE restarts
        new_test(32'd0, TS_GOOD, 3);
        pulse_start(k);
        repeat (2) @(posedge clock);
        pulse_start(k2);
        check("busy_restart_busy", 32'(busy), 32'd1);
        wait_done(k, d);
        check("busy_latency", 32'(d), 32'd10);
        check("busy_pass", 32'(pass), 32'd1);
        new_test(32'd0, TS_GOOD, 0);
        pulse_start(k);
        check("redo_done_clr", 32'(done), 32'd0);
        check("redo_pass_clr", 32'(pass), 32'd0);
        check("redo_busy", 32'(busy), 32'd1);
        check("redo_read", 32'(avm_read), 32'd1);
        wait_done(k, d);
        check("redo_latency", 32'(d), 32'd4);
        check("redo_pass", 32'(pass), 32'd1);

        // Reset in the middle of WAIT_TS
        new_test(32'd0, TS_GOOD, 0);
        pulse_start(k);
        repeat (3) @(posedge clock);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_read_low", 32'(avm_read), 32'd0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ts", timestamp_value, 32'd0);
        check("arst_error", 32'(error), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rd_hi = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (avm_read || busy || done) rd_hi++;
        end
        check("post_rst_idle", 32'(rd_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
